dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single data memory port between two requesters: the CPU datapath (multicycle controller MemRead/MemWrite path) and an external port (program loader / debug DMA).
- Sits between the requesters and the data memory.
- Sequences each access as a latched, single-cycle memory transaction with a req/ack handshake.
- Arbitrates round-robin by default and provides a CPU stall signal so the controller FSM holds state while waiting.

Parameters:
- AW, 16, address width of both requester ports and the memory port.
- DW, 16, data width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- cpu_req  input  1  CPU access request; held until cpu_ack.
- cpu_we  input  1  1 = write, 0 = read; valid while cpu_req.
- cpu_addr  input  AW  CPU address.
- cpu_wdata  input  DW  CPU write data.
- cpu_rdata  output  DW  read data; valid in the cpu_ack cycle.
- cpu_ack  output  1  one-cycle completion pulse.
- cpu_stall  output  1  cpu_req & ~cpu_ack (combinational).
- ext_req, ext_we, ext_addr, ext_wdata, ext_rdata, ext_ack  (same directions and widths as cpu_*)  external port.
- mem_addr  output  AW  to data memory.
- mem_wdata  output  DW  to data memory.
- mem_read  output  1  memory read strobe.
- mem_write  output  1  memory write strobe.
- mem_rdata  input  DW  combinational read data from the memory.
- owner  output  2  00 = none, 01 = CPU, 10 = EXT; registered.

Behaviour:
- States:
  - IDLE.
  - XFER: drive memory for exactly one cycle.
  - DONE: ack cycle, which is also an arbitration cycle.
- IDLE: if any eligible req, pick a winner, latch its we/addr/wdata, set owner, go to XFER. Otherwise stay.
- XFER:
  - mem_addr/mem_wdata come from the latch.
  - mem_read = ~we_l, mem_write = we_l; both strobes are registered-decode, glitch-free, and never both 1.
  - On the edge, capture mem_rdata into the winner's rdata register (reads only; writes leave rdata unchanged).
  - Next state is DONE.
- DONE:
  - Winner's ack = 1 for exactly one cycle.
  - Arbitrate among eligible requesters: the just-acked requester is ineligible this cycle, and its req is treated as a new request from the next cycle.
  - If there is a winner, go to XFER; otherwise go to IDLE with owner = 00.
- Latency:
  - req seen in IDLE at cycle 0 → mem strobe in cycle 1 → ack in cycle 2.
  - Back-to-back alternating requesters: one access every 2 cycles.
- Round-robin:
  - A 1-bit last-grant pointer is updated on every grant.
  - When both are eligible, the requester not last granted wins.
  - Reset pointer = EXT, so the CPU wins the first tie.
- Outside XFER, mem_read = mem_write = 0 and mem_addr/mem_wdata hold their last values.
- Requester fields sampled only at grant; changes after grant are ignored.
- req dropped before grant: withdrawn, no access.
- req dropped after grant: access still completes and ack still pulses.
- Reset (asynchronous assert, any state, including mid-XFER):
  - state = IDLE; acks, strobes, owner = 0.
  - rdata registers, mem_addr, mem_wdata = 0.
  - pointer = EXT.
  - An in-flight write is aborted; the strobe drops immediately.
- Reset deassertion is synchronised by the system; the first arbitration happens in the first clk edge after release.

Optional Feature:
- DMEM_ARB_CPU_PRIO_EN defined: fixed priority. The CPU wins every tie, the pointer is unused, and EXT can starve while the CPU requests continuously (back-to-back CPU accesses every 2 cycles).
- Undefined: round-robin as above.

Decomposition:
- Package dmem_arb_pkg:
  - state encoding constants ST_IDLE, ST_XFER, ST_DONE.
  - owner codes OWN_NONE/OWN_CPU/OWN_EXT.
  - requester index constants REQ_CPU = 0, REQ_EXT = 1.
- Sub-module rr_pick2: combinational two-way picker.
  - Inputs: eligible vector and last-grant pointer.
  - Outputs: one-hot grant.
  - Contains the DMEM_ARB_CPU_PRIO_EN variant.
- The FSM, latches and rdata registers stay in dmem_arbiter.

Test Plan:
- CPU read alone: mem[0x0040] = 0xBEEF, cpu_req/we = 0/addr = 0x0040 at cycle 0 → mem_read = 1 with mem_addr = 0x0040 in cycle 1, cpu_ack = 1 with cpu_rdata = 0xBEEF in cycle 2, cpu_stall = 1 in cycles 0–1.
- EXT write then CPU read of the same address: ext writes 0x1234 to 0x0010 → mem_write for exactly one cycle; the following CPU read of 0x0010 returns 0x1234; mem_read and mem_write are never high together.
- Both req held continuously from reset: grants CPU, EXT, CPU, EXT, with acks at cycles 2, 4, 6, 8. With DMEM_ARB_CPU_PRIO_EN: CPU acks at 2, 4, 6, 8 and no ext_ack.
- EXT req withdrawn while the CPU is in XFER → no EXT access and no ext_ack. A CPU req dropped during its XFER still gets cpu_ack.
- rst asserted mid-XFER of a write → mem_write drops asynchronously and all outputs return to reset values. After release, a pending CPU req gets a fresh, complete access.
- cpu_addr/cpu_wdata changed one cycle after grant → memory sees the originally latched values.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_CPU  = 2'b01;
    localparam logic [1:0] OWN_EXT  = 2'b10;

    localparam int unsigned REQ_CPU = 0;
    localparam int unsigned REQ_EXT = 1;

endpackage

// File: rtl/rr_pick2.sv
// Two-way combinational grant picker.
// Round-robin on the last-grant pointer by default; when DMEM_ARB_CPU_PRIO_EN
// is defined the CPU wins every tie and the pointer is ignored.
module rr_pick2
    import dmem_arb_pkg::*;
(
    input  logic [1:0] elig,
    input  logic       last,
    output logic [1:0] grant_c
);

`ifdef DMEM_ARB_CPU_PRIO_EN
    logic unused_last;

    // Fixed priority: CPU first, EXT only when the CPU is not eligible.
    always_comb begin
        unused_last = last;
        grant_c     = 2'b00;
        if (elig[REQ_CPU]) begin
            grant_c[REQ_CPU] = 1'b1;
        end else if (elig[REQ_EXT]) begin
            grant_c[REQ_EXT] = 1'b1;
        end
    end
`else
    // Round-robin: on a tie the requester not granted last time wins.
    always_comb begin
        grant_c = 2'b00;
        if (elig[REQ_CPU] && elig[REQ_EXT]) begin
            if (last == 1'(REQ_EXT)) begin
                grant_c[REQ_CPU] = 1'b1;
            end else begin
                grant_c[REQ_EXT] = 1'b1;
            end
        end else begin
            grant_c = elig;
        end
    end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: shares one memory port between the CPU datapath and an
// external loader/DMA port using IDLE -> XFER -> DONE single-access sequences.
// Optional build macro: DMEM_ARB_CPU_PRIO_EN selects fixed CPU priority.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned AW = 16,
    parameter int unsigned DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_ack,
    output logic          cpu_stall,
    input  logic          ext_req,
    input  logic          ext_we,
    input  logic [AW-1:0] ext_addr,
    input  logic [DW-1:0] ext_wdata,
    output logic [DW-1:0] ext_rdata,
    output logic          ext_ack,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_read,
    output logic          mem_write,
    input  logic [DW-1:0] mem_rdata,
    output logic [1:0]    owner
);

    state_t     state;
    logic       last_ptr;
    logic [1:0] req_v;
    logic [1:0] done_mask;
    logic [1:0] elig_v;
    logic [1:0] grant_v;

    assign cpu_stall = cpu_req & ~cpu_ack;

    // Requester just acked in DONE sits out this arbitration cycle.
    always_comb begin
        done_mask = 2'b00;
`ifndef DMEM_ARB_CPU_PRIO_EN
        if (owner == OWN_CPU) begin
            done_mask[REQ_CPU] = 1'b1;
        end
`endif
        if (owner == OWN_EXT) begin
            done_mask[REQ_EXT] = 1'b1;
        end
    end

    // Eligible requesters: live requests in IDLE and DONE, none during XFER.
    always_comb begin
        req_v                = 2'b00;
        req_v[REQ_CPU]       = cpu_req;
        req_v[REQ_EXT]       = ext_req;
        elig_v               = 2'b00;
        case (state)
            ST_IDLE: elig_v = req_v;
            ST_DONE: elig_v = req_v & ~done_mask;
            default: elig_v = 2'b00;
        endcase
    end

    rr_pick2 u_pick (
        .elig    (elig_v),
        .last    (last_ptr),
        .grant_c (grant_v)
    );

    // Access sequencer: grant latch, registered strobes, read capture and acks.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            owner     <= OWN_NONE;
            last_ptr  <= 1'(REQ_EXT);
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            cpu_rdata <= '0;
            ext_rdata <= '0;
            cpu_ack   <= 1'b0;
            ext_ack   <= 1'b0;
        end else begin
            cpu_ack <= 1'b0;
            ext_ack <= 1'b0;
            case (state)
                ST_XFER: begin
                    mem_read  <= 1'b0;
                    mem_write <= 1'b0;
                    if (mem_read) begin
                        if (owner == OWN_CPU) begin
                            cpu_rdata <= mem_rdata;
                        end else begin
                            ext_rdata <= mem_rdata;
                        end
                    end
                    cpu_ack <= (owner == OWN_CPU);
                    ext_ack <= (owner == OWN_EXT);
                    state   <= ST_DONE;
                end
                ST_IDLE, ST_DONE: begin
                    if (grant_v[REQ_CPU]) begin
                        state     <= ST_XFER;
                        owner     <= OWN_CPU;
                        last_ptr  <= 1'(REQ_CPU);
                        mem_addr  <= cpu_addr;
                        mem_wdata <= cpu_wdata;
                        mem_read  <= ~cpu_we;
                        mem_write <= cpu_we;
                    end else if (grant_v[REQ_EXT]) begin
                        state     <= ST_XFER;
                        owner     <= OWN_EXT;
                        last_ptr  <= 1'(REQ_EXT);
                        mem_addr  <= ext_addr;
                        mem_wdata <= ext_wdata;
                        mem_read  <= ~ext_we;
                        mem_write <= ext_we;
                    end else begin
                        state <= ST_IDLE;
                        owner <= OWN_NONE;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    owner     <= OWN_NONE;
                    mem_read  <= 1'b0;
                    mem_write <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a behavioural data memory.
module tb_dmem_arbiter;

    logic        clk;
    logic        rst;
    logic        cpu_req, cpu_we, ext_req, ext_we;
    logic [15:0] cpu_addr, cpu_wdata, ext_addr, ext_wdata;
    logic [15:0] cpu_rdata, ext_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        cpu_ack, cpu_stall, ext_ack, mem_read, mem_write;
    logic [1:0]  owner;

    logic [15:0] mem [0:65535];
    int          checks;
    int          errors;

    dmem_arbiter #(.AW(16), .DW(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_ack   (cpu_ack),
        .cpu_stall (cpu_stall),
        .ext_req   (ext_req),
        .ext_we    (ext_we),
        .ext_addr  (ext_addr),
        .ext_wdata (ext_wdata),
        .ext_rdata (ext_rdata),
        .ext_ack   (ext_ack),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_rdata (mem_rdata),
        .owner     (owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: combinational read, write on the rising edge.
    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
        mem[16'h0040] = 16'hBEEF;
    end
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) begin
        if (mem_write === 1'b1) mem[mem_addr] <= mem_wdata;
    end

    // Strobes must never be asserted together.
    always @(negedge clk) begin
        checks++;
        if ((mem_read & mem_write) === 1'b1) begin
            errors++;
            $display("FAIL strobe_overlap: read=%b write=%b, required not both 1", mem_read, mem_write);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        ext_req = 0; ext_we = 0; ext_addr = 0; ext_wdata = 0;
        #2 rst = 1'b0;
        tick();
        tick();
        checks++; if (owner !== 2'b00) begin errors++; $display("FAIL rst_owner: got %b exp 00", owner); end
        checks++; if ({mem_read, mem_write} !== 2'b00) begin errors++; $display("FAIL rst_strobes: got %b exp 00", {mem_read, mem_write}); end
        checks++; if ({cpu_ack, ext_ack} !== 2'b00) begin errors++; $display("FAIL rst_acks: got %b exp 00", {cpu_ack, ext_ack}); end
        checks++; if ({mem_addr, mem_wdata} !== 32'h0) begin errors++; $display("FAIL rst_mem_bus: got %h exp 0", {mem_addr, mem_wdata}); end
        checks++; if ({cpu_rdata, ext_rdata} !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h exp 0", {cpu_rdata, ext_rdata}); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_cpu_read();
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0040;
        #1;
        checks++; if (cpu_stall !== 1'b1) begin errors++; $display("FAIL rd_stall_c0: got %b exp 1", cpu_stall); end
        checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL rd_strobe_c0: got %b exp 0", mem_read); end
        tick();
        checks++; if (mem_read !== 1'b1 || mem_write !== 1'b0) begin errors++; $display("FAIL rd_strobe_c1: got r%b w%b exp r1 w0", mem_read, mem_write); end
        checks++; if (mem_addr !== 16'h0040) begin errors++; $display("FAIL rd_addr_c1: got %h exp 0040", mem_addr); end
        checks++; if (cpu_stall !== 1'b1 || cpu_ack !== 1'b0) begin errors++; $display("FAIL rd_stall_c1: got stall%b ack%b exp stall1 ack0", cpu_stall, cpu_ack); end
        checks++; if (owner !== 2'b01) begin errors++; $display("FAIL rd_owner_c1: got %b exp 01", owner); end
        tick();
        checks++; if (cpu_ack !== 1'b1) begin errors++; $display("FAIL rd_ack_c2: got %b exp 1", cpu_ack); end
        checks++; if (cpu_rdata !== 16'hBEEF) begin errors++; $display("FAIL rd_data_c2: got %h exp beef", cpu_rdata); end
        checks++; if (cpu_stall !== 1'b0 || mem_read !== 1'b0) begin errors++; $display("FAIL rd_c2_flags: got stall%b read%b exp 0 0", cpu_stall, mem_read); end
        cpu_req = 0;
        tick();
        checks++; if (cpu_ack !== 1'b0 || owner !== 2'b00) begin errors++; $display("FAIL rd_c3_idle: got ack%b owner%b exp 0 00", cpu_ack, owner); end
    endtask

    task automatic test_ext_write_cpu_read();
        ext_req = 1; ext_we = 1; ext_addr = 16'h0010; ext_wdata = 16'h1234;
        tick();
        checks++; if (mem_write !== 1'b1 || mem_read !== 1'b0) begin errors++; $display("FAIL wr_strobe_c1: got r%b w%b exp r0 w1", mem_read, mem_write); end
        checks++; if ({mem_addr, mem_wdata} !== {16'h0010, 16'h1234}) begin errors++; $display("FAIL wr_bus_c1: got %h exp 00101234", {mem_addr, mem_wdata}); end
        checks++; if (owner !== 2'b10) begin errors++; $display("FAIL wr_owner_c1: got %b exp 10", owner); end
        tick();
        checks++; if (mem_write !== 1'b0 || ext_ack !== 1'b1) begin errors++; $display("FAIL wr_c2: got write%b ack%b exp 0 1", mem_write, ext_ack); end
        checks++; if (ext_rdata !== 16'h0000) begin errors++; $display("FAIL wr_rdata_kept: got %h exp 0000", ext_rdata); end
        ext_req = 0; ext_we = 0;
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010;
        tick();
        checks++; if (mem_read !== 1'b1 || mem_addr !== 16'h0010 || owner !== 2'b01) begin errors++; $display("FAIL rbw_c1: got read%b addr%h owner%b exp 1 0010 01", mem_read, mem_addr, owner); end
        tick();
        checks++; if (cpu_ack !== 1'b1 || cpu_rdata !== 16'h1234) begin errors++; $display("FAIL rbw_c2: got ack%b data%h exp 1 1234", cpu_ack, cpu_rdata); end
        cpu_req = 0;
        tick();
    endtask

    task automatic test_both_continuous();
        logic exp_cack, exp_eack;
        logic [1:0] exp_own;
        rst = 1'b0;
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0040;
        ext_req = 1; ext_we = 0; ext_addr = 16'h0010;
        tick();
        rst = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            tick();
`ifdef DMEM_ARB_CPU_PRIO_EN
            exp_cack = (c % 2 == 0);
            exp_eack = 1'b0;
            exp_own  = 2'b01;
`else
            exp_cack = (c == 2) || (c == 6);
            exp_eack = (c == 4) || (c == 8);
            exp_own  = (c <= 2 || c == 5 || c == 6) ? 2'b01 : 2'b10;
`endif
            checks++; if ({cpu_ack, ext_ack} !== {exp_cack, exp_eack}) begin errors++; $display("FAIL rr_acks_c%0d: got %b exp %b", c, {cpu_ack, ext_ack}, {exp_cack, exp_eack}); end
            checks++; if (owner !== exp_own) begin errors++; $display("FAIL rr_owner_c%0d: got %b exp %b", c, owner, exp_own); end
            if (exp_cack) begin
                checks++; if (cpu_rdata !== 16'hBEEF) begin errors++; $display("FAIL rr_cdata_c%0d: got %h exp beef", c, cpu_rdata); end
            end
            if (exp_eack) begin
                checks++; if (ext_rdata !== 16'h1234) begin errors++; $display("FAIL rr_edata_c%0d: got %h exp 1234", c, ext_rdata); end
            end
        end
        cpu_req = 0; ext_req = 0;
        tick();
`ifndef DMEM_ARB_CPU_PRIO_EN
        checks++; if (owner !== 2'b00) begin errors++; $display("FAIL rr_end_idle: got %b exp 00", owner); end
`endif
        tick();
        tick();
    endtask

    task automatic test_withdraw();
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0040;
        ext_req = 1; ext_we = 1; ext_addr = 16'h0050; ext_wdata = 16'hDEAD;
        tick();
        checks++; if (owner !== 2'b01 || mem_read !== 1'b1) begin errors++; $display("FAIL wd_grant: got owner%b read%b exp 01 1", owner, mem_read); end
        ext_req = 0; cpu_req = 0;
        tick();
        checks++; if (cpu_ack !== 1'b1 || ext_ack !== 1'b0) begin errors++; $display("FAIL wd_ack: got c%b e%b exp c1 e0", cpu_ack, ext_ack); end
        tick();
        checks++; if ({mem_read, mem_write, owner} !== 4'b0000) begin errors++; $display("FAIL wd_idle: got %b exp 0000", {mem_read, mem_write, owner}); end
        tick();
        checks++; if (ext_ack !== 1'b0 || mem[16'h0050] !== 16'h0000) begin errors++; $display("FAIL wd_no_ext: got ack%b mem%h exp 0 0000", ext_ack, mem[16'h0050]); end
        ext_we = 0;
    endtask

    task automatic test_reset_mid_xfer();
        cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0020; cpu_wdata = 16'h5555;
        tick();
        checks++; if (mem_write !== 1'b1) begin errors++; $display("FAIL mrst_pre: got %b exp 1", mem_write); end
        #2 rst = 1'b0;
        #1;
        checks++; if ({mem_read, mem_write, cpu_ack, ext_ack, owner} !== 6'b0) begin errors++; $display("FAIL mrst_ctrl: got %b exp 000000", {mem_read, mem_write, cpu_ack, ext_ack, owner}); end
        checks++; if ({mem_addr, mem_wdata, cpu_rdata, ext_rdata} !== 64'h0) begin errors++; $display("FAIL mrst_data: got %h exp 0", {mem_addr, mem_wdata, cpu_rdata, ext_rdata}); end
        tick();
        checks++; if (mem[16'h0020] !== 16'h0000) begin errors++; $display("FAIL mrst_aborted: got %h exp 0000", mem[16'h0020]); end
        rst = 1'b1;
        tick();
        checks++; if (mem_write !== 1'b1 || {mem_addr, mem_wdata} !== {16'h0020, 16'h5555}) begin errors++; $display("FAIL mrst_retry_c1: got w%b %h exp w1 00205555", mem_write, {mem_addr, mem_wdata}); end
        tick();
        checks++; if (cpu_ack !== 1'b1 || mem[16'h0020] !== 16'h5555) begin errors++; $display("FAIL mrst_retry_c2: got ack%b mem%h exp 1 5555", cpu_ack, mem[16'h0020]); end
        cpu_req = 0; cpu_we = 0;
        tick();
    endtask

    task automatic test_field_change();
        cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0030; cpu_wdata = 16'hA5A5;
        tick();
        cpu_addr = 16'h0031; cpu_wdata = 16'hFFFF; cpu_we = 0;
        #1;
        checks++; if ({mem_addr, mem_wdata} !== {16'h0030, 16'hA5A5} || mem_write !== 1'b1) begin errors++; $display("FAIL fc_c1: got w%b %h exp w1 0030a5a5", mem_write, {mem_addr, mem_wdata}); end
        tick();
        checks++; if (cpu_ack !== 1'b1 || mem[16'h0030] !== 16'hA5A5 || mem[16'h0031] !== 16'h0000) begin errors++; $display("FAIL fc_c2: got ack%b m30=%h m31=%h exp 1 a5a5 0000", cpu_ack, mem[16'h0030], mem[16'h0031]); end
        cpu_req = 0;
        tick();
        checks++; if ({mem_read, mem_write} !== 2'b00 || mem_addr !== 16'h0030) begin errors++; $display("FAIL fc_hold: got rw%b addr%h exp 00 0030", {mem_read, mem_write}, mem_addr); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_cpu_read();
        test_ext_write_cpu_read();
        test_both_continuous();
        test_withdraw();
        test_reset_mid_xfer();
        test_field_change();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
